kv_cmd_master: RTL and testbench

KV_CMD_MASTER -- requirements
Module: kv_cmd_master

---
 rtl/kv_cmd_master.sv | 131 +++++++++++++
 tb/tb_kv_cmd_master.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kv_cmd_master.sv
// Wishbone master that turns host put/get commands into key-value store cycles.
// Optional WAIT-state abort timer is built only when KV_CMD_MASTER_TIMEOUT_EN is defined.
module kv_cmd_master #(
  parameter int DW      = 16,
  parameter int TIMEOUT = 255
) (
  input  logic          sys_clk,
  input  logic          sys_rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_we,
  input  logic [DW-1:0] cmd_adr,
  input  logic [DW-1:0] cmd_key,
  input  logic [DW-1:0] cmd_dat,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_dat,
  output logic          rsp_err,
  output logic          CYC_o,
  output logic          STB_o,
  output logic          WE_o,
  output logic [DW-1:0] ADR_o,
  output logic [DW-1:0] DAT_o,
  output logic [DW-1:0] KEY_o,
  input  logic          STALL_i,
  input  logic          ACK_i,
  input  logic [DW-1:0] DAT_i,
  output logic          RESET_o
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  state_t r_state;

`ifdef KV_CMD_MASTER_TIMEOUT_EN
  localparam int CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  localparam logic [CW-1:0] TO_VAL = CW'(TIMEOUT);

  logic [CW-1:0] r_wait_cnt;
  logic [CW-1:0] w_cnt_next;

  assign w_cnt_next = r_wait_cnt + CW'(1);
`else
  logic w_unused_timeout;

  assign w_unused_timeout = (TIMEOUT != 0);
  assign rsp_err          = 1'b0;
  assign RESET_o          = 1'b0;
`endif

  // Single registered FSM; the store sees only registered strobes and a stable request.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state   <= IDLE;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_dat   <= '0;
      CYC_o     <= 1'b0;
      STB_o     <= 1'b0;
      WE_o      <= 1'b0;
      ADR_o     <= '0;
      DAT_o     <= '0;
      KEY_o     <= '0;
`ifdef KV_CMD_MASTER_TIMEOUT_EN
      rsp_err    <= 1'b0;
      RESET_o    <= 1'b0;
      r_wait_cnt <= '0;
`endif
    end else begin
`ifdef KV_CMD_MASTER_TIMEOUT_EN
      RESET_o <= 1'b0;
`endif
      case (r_state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            WE_o      <= cmd_we;
            ADR_o     <= cmd_adr;
            KEY_o     <= cmd_key;
            DAT_o     <= cmd_dat;
            CYC_o     <= 1'b1;
            STB_o     <= 1'b1;
            cmd_ready <= 1'b0;
            r_state   <= REQ;
          end else begin
            cmd_ready <= 1'b1;
          end
        end
        REQ: begin
          if (!STALL_i) begin
            STB_o   <= 1'b0;
            // Reads are acknowledged by the store on cycle end, so gets drop CYC here.
            CYC_o   <= WE_o;
            r_state <= WAIT;
`ifdef KV_CMD_MASTER_TIMEOUT_EN
            r_wait_cnt <= '0;
`endif
          end
        end
        WAIT: begin
          if (ACK_i) begin
            rsp_dat   <= DAT_i;
            rsp_valid <= 1'b1;
            CYC_o     <= 1'b0;
            r_state   <= RESP;
`ifdef KV_CMD_MASTER_TIMEOUT_EN
            rsp_err <= 1'b0;
          end else if (w_cnt_next == TO_VAL) begin
            rsp_dat   <= '0;
            rsp_err   <= 1'b1;
            rsp_valid <= 1'b1;
            RESET_o   <= 1'b1;
            CYC_o     <= 1'b0;
            r_state   <= RESP;
          end else begin
            r_wait_cnt <= w_cnt_next;
`endif
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            r_state   <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_kv_cmd_master.sv
// Directed self-checking bench for kv_cmd_master; timeout checks follow KV_CMD_MASTER_TIMEOUT_EN.
module tb_kv_cmd_master;

  localparam int DW = 16;

  logic          sys_clk;
  logic          sys_rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_we;
  logic [DW-1:0] cmd_adr;
  logic [DW-1:0] cmd_key;
  logic [DW-1:0] cmd_dat;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_dat;
  logic          rsp_err;
  logic          CYC_o;
  logic          STB_o;
  logic          WE_o;
  logic [DW-1:0] ADR_o;
  logic [DW-1:0] DAT_o;
  logic [DW-1:0] KEY_o;
  logic          STALL_i;
  logic          ACK_i;
  logic [DW-1:0] DAT_i;
  logic          RESET_o;

  int errors = 0;
  int checks = 0;

  kv_cmd_master #(.DW(DW), .TIMEOUT(4)) dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_we   (cmd_we),
    .cmd_adr  (cmd_adr),
    .cmd_key  (cmd_key),
    .cmd_dat  (cmd_dat),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_dat  (rsp_dat),
    .rsp_err  (rsp_err),
    .CYC_o    (CYC_o),
    .STB_o    (STB_o),
    .WE_o     (WE_o),
    .ADR_o    (ADR_o),
    .DAT_o    (DAT_o),
    .KEY_o    (KEY_o),
    .STALL_i  (STALL_i),
    .ACK_i    (ACK_i),
    .DAT_i    (DAT_i),
    .RESET_o  (RESET_o)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Absolute time bound so a wedged design still ends with a report.
  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Inputs change and outputs are sampled 1ns after each rising edge.
  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic applyStimulus(input logic we, input logic [DW-1:0] adr,
                               input logic [DW-1:0] key, input logic [DW-1:0] dat);
    cmd_we    = we;
    cmd_adr   = adr;
    cmd_key   = key;
    cmd_dat   = dat;
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    sys_rst = 1'b1;
    step();
    step();
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("[TB] FAIL rst_cmd_ready: got %b want 0", cmd_ready); end
    checks++; if ({rsp_valid, rsp_err, CYC_o, STB_o, WE_o, RESET_o} !== 6'b0) begin errors++;
      $display("[TB] FAIL rst_ctrl: got %b want 000000", {rsp_valid, rsp_err, CYC_o, STB_o, WE_o, RESET_o}); end
    checks++; if ({ADR_o, DAT_o, KEY_o, rsp_dat} !== 64'h0) begin errors++;
      $display("[TB] FAIL rst_buses: got %h want 0", {ADR_o, DAT_o, KEY_o, rsp_dat}); end
    sys_rst = 1'b0;
    step();
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL rst_release_ready: got %b want 1", cmd_ready); end
  endtask

  task automatic test_insert();
    int cyc_cnt;
    cyc_cnt = 0;
    STALL_i = 1'b0;
    applyStimulus(1'b1, 16'h0000, 16'h00AA, 16'h1234);
    checks++; if ({CYC_o, STB_o, WE_o, cmd_ready} !== 4'b1110) begin errors++;
      $display("[TB] FAIL ins_req_ctrl: got %b want 1110", {CYC_o, STB_o, WE_o, cmd_ready}); end
    checks++; if ({ADR_o, KEY_o, DAT_o} !== {16'h0000, 16'h00AA, 16'h1234}) begin errors++;
      $display("[TB] FAIL ins_req_bus: got %h want 000000aa1234", {ADR_o, KEY_o, DAT_o}); end
    if (CYC_o === 1'b1) cyc_cnt++;
    step();
    checks++; if ({CYC_o, STB_o, rsp_valid} !== 3'b100) begin errors++;
      $display("[TB] FAIL ins_wait_ctrl: got %b want 100", {CYC_o, STB_o, rsp_valid}); end
    if (CYC_o === 1'b1) cyc_cnt++;
    ACK_i = 1'b1;
    DAT_i = 16'h0001;
    step();
    ACK_i = 1'b0;
    if (CYC_o === 1'b1) cyc_cnt++;
    checks++; if ({rsp_valid, rsp_err} !== 2'b10) begin errors++;
      $display("[TB] FAIL ins_rsp_flags: got %b want 10", {rsp_valid, rsp_err}); end
    checks++; if (rsp_dat !== 16'h0001) begin errors++; $display("[TB] FAIL ins_rsp_dat: got %h want 0001", rsp_dat); end
    checks++; if (cyc_cnt !== 2) begin errors++; $display("[TB] FAIL ins_cyc_cycles: got %0d want 2", cyc_cnt); end
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("[TB] FAIL ins_resp_ready: got %b want 0", cmd_ready); end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    checks++; if ({rsp_valid, cmd_ready} !== 2'b01) begin errors++;
      $display("[TB] FAIL ins_idle_return: got %b want 01", {rsp_valid, cmd_ready}); end
  endtask

  task automatic test_get();
    int stb_cnt;
    stb_cnt = 0;
    STALL_i = 1'b1;
    applyStimulus(1'b0, 16'h0002, 16'h0055, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      if (STB_o === 1'b1) stb_cnt++;
      step();
    end
    STALL_i = 1'b0;
    if (STB_o === 1'b1) stb_cnt++;
    step();
    checks++; if (stb_cnt !== 4) begin errors++; $display("[TB] FAIL get_stb_cycles: got %0d want 4", stb_cnt); end
    checks++; if ({CYC_o, STB_o, WE_o} !== 3'b000) begin errors++;
      $display("[TB] FAIL get_wait_cyc: got %b want 000", {CYC_o, STB_o, WE_o}); end
    step();
    checks++; if ({rsp_valid, CYC_o} !== 2'b00) begin errors++;
      $display("[TB] FAIL get_still_wait: got %b want 00", {rsp_valid, CYC_o}); end
    ACK_i = 1'b1;
    DAT_i = 16'h1234;
    step();
    ACK_i = 1'b0;
    checks++; if ({rsp_valid, rsp_dat, ADR_o} !== {1'b1, 16'h1234, 16'h0002}) begin errors++;
      $display("[TB] FAIL get_rsp: got %h want 1_1234_0002", {rsp_valid, rsp_dat, ADR_o}); end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    STALL_i = 1'b0;
    applyStimulus(1'b1, 16'h0005, 16'h0011, 16'hBEEF);
    step();
    ACK_i = 1'b1;
    DAT_i = 16'h0005;
    step();
    ACK_i = 1'b0;
    DAT_i = 16'hFFFF;
    for (int i = 0; i < 5; i++) begin
      checks++; if ({rsp_valid, cmd_ready, rsp_dat} !== {2'b10, 16'h0005}) begin errors++;
        $display("[TB] FAIL bp_hold_%0d: got %h want 2_0005", i, {rsp_valid, cmd_ready, rsp_dat}); end
      step();
    end
    rsp_ready = 1'b1;
    checks++; if ({rsp_valid, cmd_ready} !== 2'b10) begin errors++;
      $display("[TB] FAIL bp_handshake_cycle: got %b want 10", {rsp_valid, cmd_ready}); end
    step();
    rsp_ready = 1'b0;
    checks++; if ({rsp_valid, cmd_ready} !== 2'b01) begin errors++;
      $display("[TB] FAIL bp_idle_resume: got %b want 01", {rsp_valid, cmd_ready}); end
  endtask

  task automatic test_stray_ack();
    ACK_i = 1'b1;
    DAT_i = 16'hDEAD;
    step();
    step();
    checks++; if ({rsp_valid, cmd_ready, CYC_o} !== 3'b010) begin errors++;
      $display("[TB] FAIL stray_idle: got %b want 010", {rsp_valid, cmd_ready, CYC_o}); end
    STALL_i = 1'b1;
    applyStimulus(1'b0, 16'h0009, 16'h0001, 16'h0000);
    step();
    step();
    checks++; if ({rsp_valid, STB_o, CYC_o} !== 3'b011) begin errors++;
      $display("[TB] FAIL stray_req: got %b want 011", {rsp_valid, STB_o, CYC_o}); end
    ACK_i   = 1'b0;
    STALL_i = 1'b0;
    step();
    step();
    checks++; if ({rsp_valid, STB_o} !== 2'b00) begin errors++;
      $display("[TB] FAIL stray_wait: got %b want 00", {rsp_valid, STB_o}); end
    ACK_i = 1'b1;
    DAT_i = 16'h0042;
    step();
    ACK_i = 1'b0;
    checks++; if ({rsp_valid, rsp_dat} !== {1'b1, 16'h0042}) begin errors++;
      $display("[TB] FAIL stray_final_rsp: got %h want 1_0042", {rsp_valid, rsp_dat}); end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid_wait();
    int rsp_seen;
    rsp_seen = 0;
    STALL_i  = 1'b0;
    applyStimulus(1'b1, 16'h0003, 16'h0033, 16'h4444);
    step();
    checks++; if ({CYC_o, STB_o} !== 2'b10) begin errors++;
      $display("[TB] FAIL rmw_in_wait: got %b want 10", {CYC_o, STB_o}); end
    sys_rst = 1'b1;
    step();
    sys_rst = 1'b0;
    checks++; if ({CYC_o, STB_o, rsp_valid, ADR_o} !== {3'b000, 16'h0000}) begin errors++;
      $display("[TB] FAIL rmw_abort: got %h want 0", {CYC_o, STB_o, rsp_valid, ADR_o}); end
    for (int i = 0; i < 4; i++) begin
      step();
      if (rsp_valid !== 1'b0) rsp_seen++;
    end
    checks++; if (rsp_seen !== 0) begin errors++; $display("[TB] FAIL rmw_no_rsp: got %0d want 0", rsp_seen); end
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL rmw_ready: got %b want 1", cmd_ready); end
  endtask

  task automatic test_timeout();
    int pulses;
    int rsp_at;
    pulses  = 0;
    rsp_at  = -1;
    STALL_i = 1'b0;
    applyStimulus(1'b0, 16'h0007, 16'h0070, 16'h0000);
    step();
`ifdef KV_CMD_MASTER_TIMEOUT_EN
    for (int i = 0; i < 12; i++) begin
      step();
      if (RESET_o === 1'b1) pulses++;
      if (rsp_valid === 1'b1 && rsp_at < 0) rsp_at = i;
    end
    checks++; if (pulses !== 1) begin errors++; $display("[TB] FAIL to_reset_pulses: got %0d want 1", pulses); end
    checks++; if (rsp_at !== 3) begin errors++; $display("[TB] FAIL to_latency: got %0d want 3", rsp_at); end
    checks++; if ({rsp_valid, rsp_err, rsp_dat, CYC_o} !== {2'b11, 16'h0000, 1'b0}) begin errors++;
      $display("[TB] FAIL to_rsp: got %h want 3_0000_0", {rsp_valid, rsp_err, rsp_dat, CYC_o}); end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    applyStimulus(1'b0, 16'h0008, 16'h0080, 16'h0000);
    step();
    for (int i = 0; i < 3; i++) step();
    ACK_i = 1'b1;
    DAT_i = 16'h0077;
    step();
    ACK_i = 1'b0;
    checks++; if ({rsp_valid, rsp_err, RESET_o, rsp_dat} !== {3'b100, 16'h0077}) begin errors++;
      $display("[TB] FAIL to_ack_wins: got %h want 4_0077", {rsp_valid, rsp_err, RESET_o, rsp_dat}); end
`else
    for (int i = 0; i < 1000; i++) begin
      step();
      if (RESET_o !== 1'b0) pulses++;
      if (rsp_valid !== 1'b0 && rsp_at < 0) rsp_at = i;
    end
    checks++; if (pulses !== 0) begin errors++; $display("[TB] FAIL nto_reset_pulses: got %0d want 0", pulses); end
    checks++; if (rsp_at !== -1) begin errors++; $display("[TB] FAIL nto_rsp_early: got %0d want -1", rsp_at); end
    checks++; if ({cmd_ready, CYC_o, STB_o} !== 3'b000) begin errors++;
      $display("[TB] FAIL nto_still_wait: got %b want 000", {cmd_ready, CYC_o, STB_o}); end
    ACK_i = 1'b1;
    DAT_i = 16'h0077;
    step();
    ACK_i = 1'b0;
    checks++; if ({rsp_valid, rsp_err, rsp_dat} !== {2'b10, 16'h0077}) begin errors++;
      $display("[TB] FAIL nto_late_ack: got %h want 2_0077", {rsp_valid, rsp_err, rsp_dat}); end
`endif
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  // Scenarios run back to back; each one leaves the DUT idle with cmd_ready high.
  initial begin
    sys_rst   = 1'b1;
    cmd_valid = 1'b0;
    cmd_we    = 1'b0;
    cmd_adr   = '0;
    cmd_key   = '0;
    cmd_dat   = '0;
    rsp_ready = 1'b0;
    STALL_i   = 1'b0;
    ACK_i     = 1'b0;
    DAT_i     = '0;
    test_reset();
    test_insert();
    test_get();
    test_backpressure();
    test_stray_ack();
    test_reset_mid_wait();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
